kernel_fetch_ctrl: RTL and testbench
====================================

# kernel_fetch_ctrl

Per-layer kernel sequencer between the global layer controller and the compute engines. On a layer start it clears the bias/weight FIFOs. For each kernel of the layer it then:
- requests the kernel from PCIe until both FIFOs are full;
- hands one bias word and wordsPerKernel weight words to the active engine under engine back-pressure.

It reports the running kernel index and pulses done after the last kernel.

## Interface
Parameters:
- KN_W, 12: width of kernel count/index (up to 4095 kernels per layer).
- WPK_W, 16: width of weight-words-per-kernel count.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ena  in  1  global enable; 0 freezes FSM and counters.
- start  in  1  one-cycle layer-start pulse from global controller.
- kernelNum  in  KN_W  kernels in the layer, sampled on accepted start.
- wordsPerKernel  in  WPK_W  weight words per kernel, sampled on accepted start.
- biasFull / biasEmpty  in  1  bias FIFO flags.
- weightFull / weightEmpty  in  1  weight FIFO flags.
- engineReady  in  1  active engine accepts a word this cycle.
- pcieKernelEn  out  1  request PCIe to stream kernel data into FIFOs.
- biasRst / weightRst  out  1  FIFO clear, one cycle per layer.
- biasReadEn / weightReadEn  out  1  FIFO pop, one word per asserted cycle.
- kernelIdx  out  KN_W  index of kernel being fetched/drained.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after last kernel drained.

## Operation
States: IDLE, CLEAR, FILL, BIAS, WEIGHT, NEXT, DONE.
- IDLE: start && ena → latch kernelNum→kn, wordsPerKernel→wpk, kernelIdx=0.
  - kernelNum==0 → DONE.
  - otherwise → CLEAR.
- start outside IDLE: ignored, latched values unchanged.
- CLEAR: biasRst=weightRst=1 for exactly one cycle → FILL.
- FILL: pcieKernelEn=1 while !(biasFull && weightFull). Both full → BIAS; pcieKernelEn drops in the same cycle the full condition is seen.
- BIAS: biasReadEn = engineReady && !biasEmpty. On a pop:
  - wpk==0 → NEXT.
  - otherwise → WEIGHT, wcnt=0.
- WEIGHT: weightReadEn = engineReady && !weightEmpty. Each pop increments wcnt. Pop with wcnt==wpk-1 → NEXT. Empty or !engineReady stalls with no error.
- NEXT: kernelIdx==kn-1 → DONE; else kernelIdx+1 → FILL. FIFOs are not cleared between kernels.
- DONE: done=1 one cycle → IDLE; kernelIdx holds its last value until next accepted start.
- ena=0:
  - state, kernelIdx and wcnt hold.
  - pcieKernelEn, biasRst, weightRst, biasReadEn, weightReadEn, done forced 0.
  - busy reflects the held state.
- Counter widths: wcnt is WPK_W bits, kernelIdx is KN_W bits; compares are exact, and wraps cannot occur by construction.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, kernelIdx=0, wcnt=0, kn=wpk=0. All outputs 0 immediately, including mid-fetch. Release takes effect at the next clock edge.
- Output decode:
  - pcieKernelEn, biasRst, weightRst, busy and done decode from state only.
  - biasReadEn and weightReadEn are same-cycle combinational on engineReady and the empty flags; a pop is counted at the edge ending the cycle it was asserted.
- Latency, start sampled at edge k:
  - CLEAR during cycle k..k+1.
  - FILL from edge k+1 (pcieKernelEn high).
  - First biasReadEn possible one cycle after both full flags are seen.
- Per-kernel overhead with no stalls: 1 (BIAS) + wpk (WEIGHT) + 1 (NEXT) cycles after FILL exits.
- done asserts one cycle after the NEXT cycle of the last kernel; busy falls with done.
- Full flags asserted on entry to FILL: zero-cycle pcieKernelEn, BIAS next edge.
- Simultaneous start and rst=0: reset wins.

## Test plan
- Reset mid-WEIGHT (kernelNum=4, wpk=8, rst low at word 3) → all outputs 0 at once; after release, busy=0 and kernelIdx=0.
- kernelNum=2, wpk=3, flags full one cycle after FILL entry, engineReady=1 → per kernel: 1 biasReadEn, 3 weightReadEn. kernelIdx 0 then 1. biasRst/weightRst one cycle only. done pulses once; start-to-done = 2+2×(1+1+3+1)+1 cycles.
- Same layer, engineReady toggling 1,0,1,0 and weightEmpty high for 2 cycles mid-kernel → weightReadEn only when ready && !empty; still exactly 3 pops per kernel.
- kernelNum=0 → CLEAR skipped; no biasRst or pcieKernelEn; done one cycle after start.
- wpk=0, kernelNum=3 → 3 bias pops, 0 weight pops, done.
- ena=0 for 5 cycles during FILL, plus a second start while busy → pcieKernelEn low during freeze, resumes after; second start ignored, kn unchanged.

Source files
------------

// File: rtl/kernel_fetch_ctrl.sv
// Per-layer kernel sequencer: clears the bias/weight FIFOs on layer start, then for
// each kernel fills both FIFOs from PCIe and drains one bias word plus wpk weight words.
module kernel_fetch_ctrl #(
  parameter int KN_W  = 12,
  parameter int WPK_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [KN_W-1:0]  kernelNum,
  input  logic [WPK_W-1:0] wordsPerKernel,
  input  logic             biasFull,
  input  logic             biasEmpty,
  input  logic             weightFull,
  input  logic             weightEmpty,
  input  logic             engineReady,
  output logic             pcieKernelEn,
  output logic             biasRst,
  output logic             weightRst,
  output logic             biasReadEn,
  output logic             weightReadEn,
  output logic [KN_W-1:0]  kernelIdx,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FILL   = 3'd2,
    S_BIAS   = 3'd3,
    S_WEIGHT = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [KN_W-1:0]   kn_q, kn_d;
  logic [KN_W-1:0]   kidx_q, kidx_d;
  logic [WPK_W-1:0]  wpk_q, wpk_d;
  logic [WPK_W-1:0]  wcnt_q, wcnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      kn_q    <= '0;
      kidx_q  <= '0;
      wpk_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      kn_q    <= kn_d;
      kidx_q  <= kidx_d;
      wpk_q   <= wpk_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // FIFO pops: a read enable is a same-cycle offer gated by engineReady and !empty;
  // the word is consumed at the clock edge that ends the cycle it was asserted.
  always_comb begin
    state_d      = state_q;
    kn_d         = kn_q;
    kidx_d       = kidx_q;
    wpk_d        = wpk_q;
    wcnt_d       = wcnt_q;
    pcieKernelEn = 1'b0;
    biasRst      = 1'b0;
    weightRst    = 1'b0;
    biasReadEn   = 1'b0;
    weightReadEn = 1'b0;
    done         = 1'b0;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            kn_d    = kernelNum;
            wpk_d   = wordsPerKernel;
            kidx_d  = '0;
            wcnt_d  = '0;
            state_d = (kernelNum == '0) ? S_DONE : S_CLEAR;
          end
        end
        S_CLEAR: begin
          biasRst   = 1'b1;
          weightRst = 1'b1;
          state_d   = S_FILL;
        end
        S_FILL: begin
          // Request drops in the same cycle both full flags are seen.
          if (biasFull && weightFull) state_d = S_BIAS;
          else                        pcieKernelEn = 1'b1;
        end
        S_BIAS: begin
          biasReadEn = engineReady && !biasEmpty;
          if (biasReadEn) begin
            wcnt_d  = '0;
            state_d = (wpk_q == '0) ? S_NEXT : S_WEIGHT;
          end
        end
        S_WEIGHT: begin
          weightReadEn = engineReady && !weightEmpty;
          if (weightReadEn) begin
            wcnt_d = wcnt_q + WPK_W'(1);
            if (wcnt_q == wpk_q - WPK_W'(1)) state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          if (kidx_q == kn_q - KN_W'(1)) begin
            state_d = S_DONE;
          end else begin
            kidx_d  = kidx_q + KN_W'(1);
            state_d = S_FILL;
          end
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign kernelIdx = kidx_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_kernel_fetch_ctrl.sv
// Bench for kernel_fetch_ctrl: table of layer configurations, directed reset/freeze
// sequences and randomized FIFO/engine flags checked against a pop-order scoreboard.
module tb_kernel_fetch_ctrl;
  localparam int KN_W  = 12;
  localparam int WPK_W = 16;

  logic             clk;
  logic             rst;
  logic             ena;
  logic             start;
  logic [KN_W-1:0]  kernelNum;
  logic [WPK_W-1:0] wordsPerKernel;
  logic             biasFull, biasEmpty, weightFull, weightEmpty, engineReady;
  logic             pcieKernelEn, biasRst, weightRst, biasReadEn, weightReadEn;
  logic [KN_W-1:0]  kernelIdx;
  logic             busy, done;
  logic [2:0]       dbg_state;

  kernel_fetch_ctrl #(.KN_W(KN_W), .WPK_W(WPK_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start),
    .kernelNum(kernelNum), .wordsPerKernel(wordsPerKernel),
    .biasFull(biasFull), .biasEmpty(biasEmpty),
    .weightFull(weightFull), .weightEmpty(weightEmpty),
    .engineReady(engineReady),
    .pcieKernelEn(pcieKernelEn), .biasRst(biasRst), .weightRst(weightRst),
    .biasReadEn(biasReadEn), .weightReadEn(weightReadEn),
    .kernelIdx(kernelIdx), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected pop order: {is_weight, kernel index}
  logic [KN_W:0] exp_q[$];

  typedef struct {
    int kn;
    int wpk;
    int mode;      // 0 ideal, 1 full one cycle after FILL entry, 2 random, 3 ready toggle + empty gap
    int exp_bias;
    int exp_weight;
    int exp_rst;
    int exp_lat;   // cycles from start-sample edge to the done cycle, -1 = not checked
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive_ideal();
    ena = 1'b1; biasFull = 1'b1; weightFull = 1'b1;
    biasEmpty = 1'b0; weightEmpty = 1'b0; engineReady = 1'b1;
  endtask

  task automatic start_layer(input int kn, input int wpk);
    @(negedge clk);
    kernelNum      = KN_W'(kn);
    wordsPerKernel = WPK_W'(wpk);
    start          = 1'b1;
    ena            = 1'b1;
    exp_q.delete();
    for (int k = 0; k < kn; k++) begin
      exp_q.push_back({1'b0, KN_W'(k)});
      for (int w = 0; w < wpk; w++) exp_q.push_back({1'b1, KN_W'(k)});
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic score_pop(input string name, input logic is_w);
    logic [KN_W:0] e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s extra_pop actual_idx=%0d expected=none", name, kernelIdx);
    end else begin
      e = exp_q.pop_front();
      check(name, int'({is_w, kernelIdx}), int'(e));
    end
  endtask

  // Runs from the cycle after start was sampled until done is seen.
  task automatic monitor(input int mode, output int nb, output int nw,
                         output int nrst, output int npcie, output int lat);
    bit fill_seen;
    fill_seen = 0; nb = 0; nw = 0; nrst = 0; npcie = 0; lat = -1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      case (mode)
        0: drive_ideal();
        1: begin
          drive_ideal();
          biasFull = fill_seen; weightFull = fill_seen;
        end
        3: begin
          drive_ideal();
          engineReady = cyc[0];
          weightEmpty = (cyc == 5 || cyc == 6);
        end
        default: begin
          ena         = ($urandom_range(0, 9) != 0);
          biasFull    = $urandom_range(0, 1) == 1;
          weightFull  = $urandom_range(0, 1) == 1;
          biasEmpty   = ($urandom_range(0, 3) == 0);
          weightEmpty = ($urandom_range(0, 3) == 0);
          engineReady = ($urandom_range(0, 9) < 7);
        end
      endcase
      #1;
      if (pcieKernelEn) begin
        fill_seen = 1;
        npcie++;
        check("pcie_gate", int'(!ena || (biasFull && weightFull)), 0);
      end
      if (biasRst || weightRst) begin
        nrst++;
        check("rst_pair", int'(weightRst), int'(biasRst));
      end
      if (biasReadEn) begin
        nb++;
        check("bias_gate", int'(ena && engineReady && !biasEmpty), 1);
        score_pop("bias_pop", 1'b0);
      end
      if (weightReadEn) begin
        nw++;
        check("weight_gate", int'(ena && engineReady && !weightEmpty), 1);
        score_pop("weight_pop", 1'b1);
      end
      if (done) begin
        lat = cyc;
        break;
      end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=none expected=done_within_3000");
    end
  endtask

  task automatic check_after(input int kn);
    @(negedge clk);
    drive_ideal();
    #1;
    check("done_single", int'(done), 0);
    check("busy_idle", int'(busy), 0);
    check("idx_hold", int'(kernelIdx), (kn == 0) ? 0 : kn - 1);
  endtask

  task automatic run_vec(input vec_t v);
    int nb, nw, nrst, npcie, lat;
    start_layer(v.kn, v.wpk);
    monitor(v.mode, nb, nw, nrst, npcie, lat);
    check("bias_pops", nb, v.exp_bias);
    check("weight_pops", nw, v.exp_weight);
    check("rst_cycles", nrst, v.exp_rst);
    check("queue_drained", exp_q.size(), 0);
    if (v.kn == 0) check("pcie_none", npcie, 0);
    if (v.exp_lat >= 0) check("latency", lat, v.exp_lat);
    check_after(v.kn);
  endtask

  initial begin
    int nb, nw, nrst, npcie, lat, kn, wpk;
    vec_t rv;

    vecs[0] = '{2, 3, 1, 2, 6, 1, 15};
    vecs[1] = '{2, 3, 0, 2, 6, 1, 14};
    vecs[2] = '{0, 5, 0, 0, 0, 0, 1};
    vecs[3] = '{3, 0, 0, 3, 0, 1, 11};
    vecs[4] = '{1, 1, 1, 1, 1, 1, 7};
    vecs[5] = '{4, 2, 0, 4, 8, 1, 22};
    vecs[6] = '{2, 3, 3, 2, 6, 1, -1};
    vecs[7] = '{3, 2, 2, 3, 6, 1, -1};

    rst = 1'b0; ena = 1'b0; start = 1'b0; kernelNum = '0; wordsPerKernel = '0;
    biasFull = 1'b0; weightFull = 1'b0; biasEmpty = 1'b1; weightEmpty = 1'b1;
    engineReady = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive_ideal();
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_outs", int'({pcieKernelEn, biasRst, weightRst, biasReadEn, weightReadEn, done}), 0);
    check("reset_idx", int'(kernelIdx), 0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Asynchronous reset while the fourth weight word of kernel 0 is offered.
    start_layer(4, 8);
    nw = 0;
    for (int c = 0; c < 200 && nw < 3; c++) begin
      @(negedge clk);
      drive_ideal();
      #1;
      if (weightReadEn) nw++;
    end
    @(negedge clk);
    drive_ideal();
    #1;
    check("word3_offered", int'(weightReadEn), 1);
    rst = 1'b0;
    #1;
    check("rst_outs_now", int'({pcieKernelEn, biasRst, weightRst, biasReadEn, weightReadEn, done}), 0);
    check("rst_busy_now", int'(busy), 0);
    check("rst_idx_now", int'(kernelIdx), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_idx", int'(kernelIdx), 0);

    // Freeze during FILL, with extra start pulses that must be ignored.
    start_layer(3, 2);
    @(negedge clk);
    drive_ideal(); biasFull = 1'b0; weightFull = 1'b0;
    #1;
    check("clear_pulse", int'(biasRst && weightRst), 1);
    @(negedge clk);
    #1;
    check("fill_pcie", int'(pcieKernelEn), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ena = 1'b0;
      start = (c == 2);
      kernelNum = KN_W'(7); wordsPerKernel = WPK_W'(9);
      #1;
      check("freeze_pcie", int'(pcieKernelEn), 0);
      check("freeze_busy", int'(busy), 1);
    end
    @(negedge clk);
    ena = 1'b1; start = 1'b1;
    #1;
    check("resume_pcie", int'(pcieKernelEn), 1);
    @(posedge clk);
    #1 start = 1'b0;
    monitor(0, nb, nw, nrst, npcie, lat);
    check("freeze_bias_pops", nb, 3);
    check("freeze_weight_pops", nw, 6);
    check("freeze_queue", exp_q.size(), 0);
    check_after(3);

    // Randomized layers and flag activity.
    for (int i = 0; i < 10; i++) begin
      kn  = $urandom_range(0, 4);
      wpk = $urandom_range(0, 5);
      rv  = '{kn, wpk, 2, kn, kn * wpk, (kn != 0) ? 1 : 0, -1};
      run_vec(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
